// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and request/response record types for the
// initiator-side bridge and its response FIFO.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
  } ahb_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } ahb_rsp_t;

  // Word address to AHB byte address (word aligned).
  function automatic logic [31:0] word_to_byte_addr(input logic [29:0] addr);
    return {addr, 2'b00};
  endfunction

endpackage

// File: rtl/ahb_rsp_fifo.sv
// Synchronous response FIFO of ahb_rsp_t records. The head is presented
// combinationally and forced to zero while empty so the consumer side
// never sees stale data. DEPTH must be a power of two (>= 2).
module ahb_rsp_fifo
  import ahb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  ahb_rsp_t                 push_data,
  input  logic                     pop,
  output logic                     valid,
  output ahb_rsp_t                 head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  ahb_rsp_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign valid   = (count_reg != '0);
  assign full    = (count_reg == FULL_COUNT);
  assign do_pop  = pop && valid;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = valid ? mem[rd_ptr_reg] : '0;
  assign count   = count_reg;

  // Storage write; contents need no reset because reads are gated by valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ahb_master_bridge.sv
// Valid/ready word request stream to AHB-Lite master bridge.
// Two pipeline stages: A holds the transfer in its address phase, D the
// transfer in its data phase. A kill bit suppresses the address phase during
// the two-cycle ERROR response so the pending A transfer is re-issued cleanly.
// Responses are returned in order through ahb_rsp_fifo; requests are only
// accepted while FIFO entries plus in-flight transfers stay below RSP_DEPTH.
// Optional: define AHB_ERR_STICKY_EN to add o_err_sticky, which latches the
// first error response and then stops accepting new requests.
module ahb_master_bridge
  import ahb_pkg::*;
#(
  parameter int RSP_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [29:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP
`ifdef AHB_ERR_STICKY_EN
  ,
  output logic        o_err_sticky
`endif
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int SW = CW + 2;

  // Address-phase stage
  logic        a_valid_reg, a_valid_next;
  logic        a_we_reg,    a_we_next;
  logic [29:0] a_addr_reg,  a_addr_next;
  logic [31:0] a_wdata_reg, a_wdata_next;
  // Data-phase stage
  logic        d_valid_reg, d_valid_next;
  logic        d_we_reg,    d_we_next;
  logic [31:0] d_wdata_reg, d_wdata_next;
  // Kill: address phase suppressed while an ERROR response finishes
  logic        kill_reg,    kill_next;

  logic          advance;
  logic          retire;
  logic          req_fire;
  logic          credit_ok;
  logic          issue_block;
  logic [SW-1:0] in_flight;
  logic [CW-1:0] fifo_count;
  ahb_rsp_t      rsp_push_data;
  ahb_rsp_t      rsp_head;
  logic          unused_hresp_hi;

  assign unused_hresp_hi = HRESP[1];

  // Pipeline moves only when the bus completes and no error is unwinding.
  assign advance  = HREADY && !kill_reg;
  // The data phase ends whenever HREADY is high, including the second error cycle.
  assign retire   = d_valid_reg && HREADY;

  // Credit uses registered occupancy only; a same-cycle pop does not free a slot.
  assign in_flight = SW'(fifo_count) + SW'(a_valid_reg) + SW'(d_valid_reg);
  assign credit_ok = (in_flight < SW'(RSP_DEPTH));

  assign o_req_ready = (!a_valid_reg || advance) && credit_ok && !issue_block;
  assign req_fire    = i_req_valid && o_req_ready;

  // Bus outputs come straight from the stage registers, so they hold during waits.
  assign HTRANS = (a_valid_reg && !kill_reg) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = word_to_byte_addr(a_addr_reg);
  assign HWRITE = a_we_reg;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;
  assign HWDATA = d_wdata_reg;

  // Retired transfer record: writes report zero data.
  always_comb begin
    rsp_push_data       = '0;
    rsp_push_data.rdata = d_we_reg ? 32'h0 : HRDATA;
    rsp_push_data.err   = HRESP[0];
  end

  // Next-state for the A/D stages and the kill bit.
  always_comb begin
    a_valid_next = a_valid_reg;
    a_we_next    = a_we_reg;
    a_addr_next  = a_addr_reg;
    a_wdata_next = a_wdata_reg;
    d_valid_next = d_valid_reg;
    d_we_next    = d_we_reg;
    d_wdata_next = d_wdata_reg;
    kill_next    = kill_reg;

    if (advance) begin
      d_valid_next = a_valid_reg;
      d_we_next    = a_we_reg;
      d_wdata_next = a_wdata_reg;
      a_valid_next = 1'b0;
    end else if (kill_reg && HREADY) begin
      // Second error cycle: D leaves, A stays put for re-issue.
      d_valid_next = 1'b0;
      kill_next    = 1'b0;
    end else if (d_valid_reg && !HREADY && HRESP[0]) begin
      // First error cycle: cancel the pending address phase.
      kill_next = 1'b1;
    end

    if (req_fire) begin
      a_valid_next = 1'b1;
      a_we_next    = i_req_we;
      a_addr_next  = i_req_addr;
      a_wdata_next = i_req_wdata;
    end
  end

  // Stage and kill registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_valid_reg <= 1'b0;
      a_we_reg    <= 1'b0;
      a_addr_reg  <= '0;
      a_wdata_reg <= '0;
      d_valid_reg <= 1'b0;
      d_we_reg    <= 1'b0;
      d_wdata_reg <= '0;
      kill_reg    <= 1'b0;
    end else begin
      a_valid_reg <= a_valid_next;
      a_we_reg    <= a_we_next;
      a_addr_reg  <= a_addr_next;
      a_wdata_reg <= a_wdata_next;
      d_valid_reg <= d_valid_next;
      d_we_reg    <= d_we_next;
      d_wdata_reg <= d_wdata_next;
      kill_reg    <= kill_next;
    end
  end

`ifdef AHB_ERR_STICKY_EN
  logic err_sticky_reg;

  // Latch any error response until reset; in-flight transfers still drain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_sticky_reg <= 1'b0;
    end else if (retire && HRESP[0]) begin
      err_sticky_reg <= 1'b1;
    end
  end

  assign issue_block  = err_sticky_reg;
  assign o_err_sticky = err_sticky_reg;
`else
  assign issue_block = 1'b0;
`endif

  ahb_rsp_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (retire),
    .push_data (rsp_push_data),
    .pop       (i_rsp_ready),
    .valid     (o_rsp_valid),
    .head      (rsp_head),
    .count     (fifo_count)
  );

  assign o_rsp_rdata = rsp_head.rdata;
  assign o_rsp_err   = rsp_head.err;

endmodule

// File: tb/tb_ahb_master_bridge.sv
// Bench for ahb_master_bridge: behavioural AHB slave with wait/error
// injection, in-order expected-response queue, directed and random traffic.
module tb_ahb_master_bridge;
  import ahb_pkg::*;

  localparam int RSP_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [29:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic [1:0]  HRESP = 2'b00;
`ifdef AHB_ERR_STICKY_EN
  logic        err_sticky;
`endif

  always #5 clk = ~clk;

  ahb_master_bridge #(.RSP_DEPTH(RSP_DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .HADDR       (HADDR),
    .HWRITE      (HWRITE),
    .HTRANS      (HTRANS),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HWDATA      (HWDATA),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP)
`ifdef AHB_ERR_STICKY_EN
    ,
    .o_err_sticky(err_sticky)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Shared knobs: wait_cfg < 0 selects random 0..2 wait states per transfer.
  int   wait_cfg = 0;
  logic rand_err = 1'b0;

  function automatic logic slave_err(input logic [29:0] a);
    return (a == 30'h8) || (rand_err && ((a % 13) == 5));
  endfunction

  // Slave memory and the reference model's own view of memory.
  logic [31:0] smem [64];
  logic [31:0] mmem [64];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [29:0] addr;
    logic        we;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural slave: decides this cycle's HREADY/HRESP at the falling edge,
  // then, if the cycle completes, retires the data phase and samples a new address.
  logic        s_valid = 1'b0;
  logic        s_write = 1'b0;
  logic        s_err = 1'b0;
  logic        s_err_first = 1'b0;
  logic [29:0] s_addr = '0;
  int          s_wait = 0;
  logic        hold_chk = 1'b0;
  logic [31:0] hold_addr = '0;
  logic        hold_write = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      s_valid = 1'b0;
      s_err_first = 1'b0;
      hold_chk = 1'b0;
      HREADY = 1'b1;
      HRESP = HRESP_OKAY;
      HRDATA = '0;
    end else begin
      if (hold_chk) begin
        check("hold_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
        check("hold_haddr", HADDR, hold_addr);
        check("hold_hwrite", 32'(HWRITE), 32'(hold_write));
      end
      if (!s_valid) begin
        HREADY = 1'b1;
        HRESP = HRESP_OKAY;
      end else if (s_wait > 0) begin
        HREADY = 1'b0;
        HRESP = HRESP_OKAY;
        s_wait--;
      end else if (s_err && !s_err_first) begin
        HREADY = 1'b0;
        HRESP = HRESP_ERROR;
        s_err_first = 1'b1;
      end else begin
        if (s_err) check("err2_htrans_idle", 32'(HTRANS), 32'(HTRANS_IDLE));
        HREADY = 1'b1;
        HRESP = s_err ? HRESP_ERROR : HRESP_OKAY;
      end
      HRDATA = (s_valid && !s_write) ? smem[s_addr[5:0]] : $urandom;
      hold_chk = !HREADY && (HRESP == HRESP_OKAY) && (HTRANS == HTRANS_NONSEQ);
      hold_addr = HADDR;
      hold_write = HWRITE;
      if (HREADY) begin
        if (s_valid && s_write && !s_err) smem[s_addr[5:0]] = HWDATA;
        s_valid = (HTRANS == HTRANS_NONSEQ);
        if (s_valid) begin
          s_addr = HADDR[31:2];
          s_write = HWRITE;
          s_err = slave_err(HADDR[31:2]);
          s_err_first = 1'b0;
          s_wait = (wait_cfg < 0) ? int'($urandom_range(2, 0)) : wait_cfg;
        end
      end
    end
  end

  // One bus cycle: drive inputs after the slave has settled, then observe handshakes.
  task automatic step(input logic v, input logic we, input logic [29:0] addr,
                      input logic [31:0] wd, input logic rr, output logic acc);
    exp_t e;
    @(negedge clk);
    #1;
    i_req_valid = v;
    i_req_we = we;
    i_req_addr = addr;
    i_req_wdata = wd;
    i_rsp_ready = rr;
    #1;
    acc = v && o_req_ready;
    if (acc) begin
      e.addr = addr;
      e.we = we;
      e.err = slave_err(addr);
      e.rdata = we ? 32'h0 : mmem[addr[5:0]];
      if (we && !e.err) mmem[addr[5:0]] = wd;
      exp_q.push_back(e);
    end
    if (o_rsp_valid && rr) begin
      if (exp_q.size() == 0) begin
        check("rsp_spurious", 32'(o_rsp_valid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        $display("rsp %s addr=0x%02h rdata=0x%08h err=%0d", e.we ? "WR" : "RD",
                 e.addr, o_rsp_rdata, o_rsp_err);
        check("rsp_rdata", o_rsp_rdata, e.rdata);
        check("rsp_err", 32'(o_rsp_err), 32'(e.err));
      end
    end
  endtask

  task automatic drain();
    logic acc;
    int n = 0;
    while ((exp_q.size() != 0 || o_rsp_valid) && n < 300) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, acc);
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_htrans"}, 32'(HTRANS), 32'(HTRANS_IDLE));
    check({tag, "_haddr"}, HADDR, 32'h0);
    check({tag, "_hwrite"}, 32'(HWRITE), 32'h0);
    check({tag, "_hwdata"}, HWDATA, 32'h0);
    check({tag, "_req_ready"}, 32'(o_req_ready), 32'h1);
    check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'h0);
    check({tag, "_rsp_rdata"}, o_rsp_rdata, 32'h0);
    check({tag, "_rsp_err"}, 32'(o_rsp_err), 32'h0);
`ifdef AHB_ERR_STICKY_EN
    check({tag, "_sticky"}, 32'(err_sticky), 32'h0);
`endif
  endtask

  initial begin
    logic acc;
    int nacc;
    int rnd_acc;
    logic [29:0] ra;

    for (int i = 0; i < 64; i++) begin
      smem[i] = 32'hC0DE0000 ^ (32'(i) * 32'h00010101);
      mmem[i] = smem[i];
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_idle_state("reset");
    check("hsize", 32'(HSIZE), 32'(HSIZE_WORD));
    check("hburst", 32'(HBURST), 32'(HBURST_SINGLE));

    // Single write, zero wait states
    wait_cfg = 0;
    step(1'b1, 1'b1, 30'h10, 32'hDEADBEEF, 1'b1, acc);
    check("t1_acc", 32'(acc), 32'h1);
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("t1_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    check("t1_haddr", HADDR, 32'h40);
    check("t1_hwrite", 32'(HWRITE), 32'h1);
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("t1_hwdata", HWDATA, 32'hDEADBEEF);
    drain();

    // Read with two wait states; a following read waits in the address phase
    smem[3] = 32'h12345678;
    mmem[3] = 32'h12345678;
    wait_cfg = 2;
    step(1'b1, 1'b0, 30'h3, '0, 1'b1, acc);
    check("t2_acc0", 32'(acc), 32'h1);
    step(1'b1, 1'b0, 30'h4, '0, 1'b1, acc);
    check("t2_acc1", 32'(acc), 32'h1);
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("t2_wait1_haddr", HADDR, 32'h10);
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("t2_wait2_haddr", HADDR, 32'h10);
    check("t2_wait2_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    drain();

    // Four back-to-back reads, zero wait
    wait_cfg = 0;
    for (int i = 0; i < 5; i++) begin
      step(i < 4, 1'b0, 30'(32 + i), '0, 1'b1, acc);
      if (i < 4) check("t3_acc", 32'(acc), 32'h1);
      if (i > 0) begin
        check("t3_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
        check("t3_haddr", HADDR, 32'((32 + i - 1) * 4));
      end
    end
    drain();

    // Consumer stalled: credit limits acceptance to RSP_DEPTH
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      step(nacc < 6, 1'b0, 30'(40 + nacc), '0, 1'b0, acc);
      if (acc) nacc++;
    end
    check("t4_accepted", 32'(nacc), 32'(RSP_DEPTH));
    check("t4_ready_low", 32'(o_req_ready), 32'h0);
    step(1'b1, 1'b0, 30'(44), '0, 1'b1, acc);
    check("t4_no_same_cycle_credit", 32'(acc), 32'h0);
    step(1'b1, 1'b0, 30'(44), '0, 1'b0, acc);
    check("t4_accept_after_pop", 32'(acc), 32'h1);
    step(1'b1, 1'b0, 30'(45), '0, 1'b0, acc);
    check("t4_full_again", 32'(acc), 32'h0);
    drain();

    // Randomized traffic
    wait_cfg = -1;
`ifdef AHB_ERR_STICKY_EN
    rand_err = 1'b0;
`else
    rand_err = 1'b1;
`endif
    rnd_acc = 0;
    for (int i = 0; i < 400; i++) begin
      ra = 30'($urandom_range(63, 16));
      step(($urandom % 10) < 7, 1'($urandom), ra, $urandom, ($urandom % 4) != 0, acc);
      if (acc) rnd_acc++;
    end
    drain();
    $display("random phase: %0d requests accepted", rnd_acc);
    wait_cfg = 0;
    rand_err = 1'b0;

    // ERROR on a read followed by a write that must be re-issued
    step(1'b1, 1'b0, 30'h8, '0, 1'b1, acc);
    check("t5_acc_rd", 32'(acc), 32'h1);
    step(1'b1, 1'b1, 30'h9, 32'hCAFEF00D, 1'b1, acc);
    check("t5_acc_wr", 32'(acc), 32'h1);
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("t5_err2_idle", 32'(HTRANS), 32'(HTRANS_IDLE));
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("t5_reissue_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    check("t5_reissue_haddr", HADDR, 32'h24);
    check("t5_reissue_hwrite", 32'(HWRITE), 32'h1);
`ifdef AHB_ERR_STICKY_EN
    check("t5_sticky", 32'(err_sticky), 32'h1);
    check("t5_sticky_blocks", 32'(o_req_ready), 32'h0);
`endif
    drain();
`ifdef AHB_ERR_STICKY_EN
    step(1'b1, 1'b0, 30'h11, '0, 1'b1, acc);
    check("t5_sticky_no_accept", 32'(acc), 32'h0);
`endif
    do_reset();
    check_idle_state("t5_reset");

    // Reset while a read sits in a stretched data phase
    wait_cfg = 3;
    step(1'b1, 1'b0, 30'h5, '0, 1'b1, acc);
    check("t6_acc", 32'(acc), 32'h1);
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check("t6_wait_hready", 32'(HREADY), 32'h0);
    do_reset();
    check_idle_state("t6_reset");

    // Normal operation after the mid-transfer reset
    wait_cfg = 0;
    step(1'b1, 1'b1, 30'h30, 32'h0BADF00D, 1'b1, acc);
    check("t7_acc_wr", 32'(acc), 32'h1);
    step(1'b1, 1'b0, 30'h30, '0, 1'b1, acc);
    check("t7_acc_rd", 32'(acc), 32'h1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got 0x00000001, expected 0x00000000");
    $fatal(1, "simulation time limit");
  end

endmodule
